force_release_bank: RTL and testbench
=====================================

Name: force_release_bank

Overview:
Parametrised bank of NCH force/release channels, each WIDTH bits. It gives hardware control of the force/release semantics used in our simulation-control tests, with per-bit (partial) forcing and two channel kinds:
- continuous-assign: after release, the output follows its driver immediately.
- variable: after release, the output holds the forced value until the next driver update.
Forcing and release are driven through a valid/ready command port, with a separate valid/ready response port for readback and status.

Parameters:
NCH, 4, number of channels (1..256)
WIDTH, 32, bits per channel (1..512)
HELD_MASK, 0, NCH-bit vector; bit c=1 makes channel c variable-kind, 0 makes it continuous-kind

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous reset, active-high
drv_val  in  NCH*WIDTH  driver value per channel; channel c at bits [c*WIDTH +: WIDTH]
drv_en  in  NCH  driver-update strobe per channel; used by variable-kind channels only
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_op  in  2  0=FORCE, 1=RELEASE, 2=READ, 3=STATUS
cmd_ch  in  8  target channel
cmd_mask  in  WIDTH  bit select for FORCE/RELEASE
cmd_data  in  WIDTH  force value (FORCE only)
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_data  out  WIDTH  response payload
rsp_err  out  1  response flags an illegal channel
out_val  out  NCH*WIDTH  effective value per channel
forced_any  out  NCH  OR-reduce of each channel's force mask

Behaviour:
- Per-channel state: fmask[WIDTH], fval[WIDTH], held[WIDTH] (held is used by variable-kind channels only).
- base = HELD_MASK[c] ? held : drv_val slice.
- out_val slice = (fmask & fval) | (~fmask & base). This path is combinational from registers and drv_val.
- held update each cycle, per bit:
  - if fmask=1: held <= fval (procedural updates are ignored while forced).
  - else if drv_en[c]: held <= drv_val.
  - else: held keeps its value.
- Release on a variable-kind channel therefore retains the forced value until the next drv_en. A continuous-kind channel follows drv_val in the cycle after commit.
- FSM states IDLE, EXEC, RESP.
  - IDLE: cmd_ready=1. On cmd_valid, latch op/ch/mask/data and go to EXEC.
  - EXEC: one cycle. Commit the operation at the end of this cycle. Compute rsp_data and rsp_err. Go to RESP.
  - RESP: rsp_valid=1, with rsp_data and rsp_err held stable. On rsp_ready, go to IDLE. cmd_ready=0 in both EXEC and RESP.
- Operations:
  - FORCE: fmask |= mask; fval = (fval & ~mask) | (data & mask); rsp_data = new fmask.
  - RELEASE: fmask &= ~mask; rsp_data = new fmask.
  - READ: rsp_data = out_val slice as sampled in EXEC.
  - STATUS: rsp_data = fmask.
- Latency: command accepted on cycle N. New out_val is visible from cycle N+2. rsp_valid rises on cycle N+2. Back-to-back throughput is one command per 3 cycles, because IDLE is re-entered the cycle after rsp_ready.
- Boundary conditions:
  - cmd_ch >= NCH: no state change; rsp_err=1; rsp_data=0.
  - mask=0: no-op, but a normal response is still returned.
  - FORCE over already-forced bits: the new data overwrites fval.
  - RELEASE of unforced bits: no effect.
  - drv_en in the same cycle as a FORCE commit: the force wins on masked bits; drv_val updates the unmasked bits.
- Reset (sync, rst=1 at posedge):
  - fmask=0, fval=0, held=0.
  - FSM=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0.
  - cmd_ready=0 while rst is high.
  - Reset asserted mid-EXEC or mid-RESP aborts the command; there is no response and no commit.
  - forced_any=0 after reset.

Test Plan:
- Reset, NCH=4, WIDTH=32, HELD_MASK=4'b0100, drv_val all channels 0xAAAAAAAA → every out_val slice=0xAAAAAAAA, forced_any=0, cmd_ready=1 the cycle after rst drops.
- FORCE ch0 mask 0xFFFFFFFF data 0x55555555 accepted cycle N → out ch0=0x55555555 from N+2; rsp_data=0xFFFFFFFF; changing drv ch0 to 0x12345678 leaves out ch0 unchanged; RELEASE → out ch0=0x12345678 on the cycle after commit.
- Partial: FORCE ch1 mask 0x0000FFFF data 0x00005555, drv 0xAAAAAAAA → READ ch1 returns 0xAAAA5555; STATUS ch1 returns 0x0000FFFF; RELEASE mask 0x0000FFFF → 0xAAAAAAAA.
- Variable ch2: drv_en with 0xAAAAAAAA, FORCE full 0x55555555, drv_en with 0x12345678 (ignored), RELEASE → out ch2 stays 0x55555555; next drv_en with 0xAAAAAAAA → 0xAAAAAAAA.
- Same-cycle conflict: drv_en ch2 with 0xFFFFFFFF in the EXEC cycle of FORCE ch2 mask 0xFF000000 data 0 → out ch2=0x00FFFFFF.
- cmd_ch=7 → rsp_err=1, rsp_data=0, no state change. Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stable, cmd_ready=0. Assert rst during RESP → rsp_valid=0 the next cycle and all forces cleared.

Source files
------------

// File: rtl/force_release_bank_if.sv
// force_release_bank_if: command/response valid-ready bundle; master issues cmd_* and rsp_ready, slave returns cmd_ready and rsp_*
interface force_release_bank_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [7:0]       cmd_ch;
  logic [WIDTH-1:0] cmd_mask;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_mask, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_mask, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/force_release_bank.sv
// force_release_bank: NCH per-bit force/release channels (clk, rst, drv_val/drv_en in, bus cmd/rsp slave, out_val/forced_any out)
module force_release_bank #(
  parameter int             NCH       = 4,
  parameter int             WIDTH     = 32,
  parameter logic [NCH-1:0] HELD_MASK = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] drv_val,
  input  logic [NCH-1:0]       drv_en,
  force_release_bank_if.slave  bus,
  output logic [NCH*WIDTH-1:0] out_val,
  output logic [NCH-1:0]       forced_any
);
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] fmask [NCH];
  logic [WIDTH-1:0] fval  [NCH];
  logic [WIDTH-1:0] held  [NCH];
  logic [WIDTH-1:0] ov    [NCH];
  logic [1:0]       op;
  logic [7:0]       ch;
  logic [WIDTH-1:0] mask, data, rd;
  logic [IW-1:0]    idx;
  logic             ok;
  assign idx = ch[IW-1:0];
  assign ok  = {1'b0, ch} < 9'(NCH);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign ov[c] = (fmask[c] & fval[c]) |
                   (~fmask[c] & (HELD_MASK[c] ? held[c] : drv_val[c*WIDTH +: WIDTH]));
    assign out_val[c*WIDTH +: WIDTH] = ov[c];
    assign forced_any[c] = |fmask[c];
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (bus.cmd_valid ? EXEC : IDLE) :
              state == EXEC ? RESP : (bus.rsp_ready ? IDLE : RESP);
    bus.cmd_ready = state == IDLE && !rst;
    bus.rsp_valid = state == RESP;
    rd = !ok          ? '0 :
         op == 2'd0   ? fmask[idx] | mask :
         op == 2'd1   ? fmask[idx] & ~mask :
         op == 2'd2   ? ov[idx] : fmask[idx];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        fmask[i] <= '0;
        fval[i]  <= '0;
        held[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++)
        held[i] <= (fmask[i] & fval[i]) |
                   (~fmask[i] & (drv_en[i] ? drv_val[i*WIDTH +: WIDTH] : held[i]));
      if (state == IDLE && bus.cmd_valid) begin
        op   <= bus.cmd_op;
        ch   <= bus.cmd_ch;
        mask <= bus.cmd_mask;
        data <= bus.cmd_data;
      end
      if (state == EXEC) begin
        bus.rsp_data <= rd;
        bus.rsp_err  <= !ok;
        if (ok && op == 2'd0) begin
          fmask[idx] <= fmask[idx] | mask;
          fval[idx]  <= (fval[idx] & ~mask) | (data & mask);
        end
        if (ok && op == 2'd1)
          fmask[idx] <= fmask[idx] & ~mask;
      end
    end
  end
endmodule

// File: tb/tb_force_release_bank.sv
// tb_force_release_bank: scoreboard bench for force_release_bank (NCH=4, WIDTH=32, ch2 variable-kind)
module tb_force_release_bank;
  localparam logic [1:0] OP_F = 2'd0, OP_R = 2'd1, OP_RD = 2'd2, OP_ST = 2'd3;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] drv_val;
  logic [3:0]   drv_en;
  logic [127:0] out_val;
  logic [3:0]   forced_any;
  logic [127:0] snap;
  logic [32:0]  sb [$];
  int           n_tests = 0;
  int           n_fail = 0;
  force_release_bank_if #(.WIDTH(32)) bus ();
  force_release_bank #(.NCH(4), .WIDTH(32), .HELD_MASK(4'b0100)) dut (
    .clk(clk), .rst(rst), .drv_val(drv_val), .drv_en(drv_en),
    .bus(bus), .out_val(out_val), .forced_any(forced_any)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ov(input int c);
    return out_val[c*32 +: 32];
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic pulse(input int c, input logic [31:0] v);
    drv_val[c*32 +: 32] = v;
    drv_en[c] = 1'b1;
    @(negedge clk);
    drv_en[c] = 1'b0;
  endtask
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] ch, input logic [31:0] mask,
                        input logic [31:0] data, input logic [32:0] exp, input logic [3:0] en_exec,
                        input int hold, input bit abort);
    int k;
    logic [32:0] e;
    sb.push_back(exp);
    k = 0;
    while (!bus.cmd_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_ch = ch;
    bus.cmd_mask = mask;
    bus.cmd_data = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    drv_en = en_exec;
    k = 1;
    while (!bus.rsp_valid && k < 10) begin
      @(negedge clk);
      drv_en = '0;
      k++;
    end
    check("latency", k, 2);
    snap = out_val;
    e = sb.pop_front();
    check("rsp", {bus.rsp_err, bus.rsp_data}, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_rsp", {bus.rsp_err, bus.rsp_data}, e);
      check("hold_cmd_ready", bus.cmd_ready, 0);
    end
    if (abort) rst = 1'b1;
    else begin
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
    end
  endtask
  initial begin
    rst = 1'b1;
    drv_val = {4{32'hAAAAAAAA}};
    drv_en = '1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_ch = '0;
    bus.cmd_mask = '0;
    bus.cmd_data = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    drv_en = '0;
    check("init_cmd_ready", bus.cmd_ready, 1);
    for (int c = 0; c < 4; c++) check("init_out", ov(c), 32'hAAAAAAAA);
    check("init_forced_any", forced_any, 0);
    do_cmd(OP_F, 0, 32'hFFFFFFFF, 32'h55555555, {1'b0, 32'hFFFFFFFF}, '0, 0, 0);
    check("f0_out_n2", snap[31:0], 32'h55555555);
    drv_val[31:0] = 32'h12345678;
    @(negedge clk);
    check("f0_drv_ignored", ov(0), 32'h55555555);
    check("f0_forced_any", forced_any, 4'b0001);
    do_cmd(OP_R, 0, 32'hFFFFFFFF, 32'h0, {1'b0, 32'h0}, '0, 0, 0);
    check("r0_out_n2", snap[31:0], 32'h12345678);
    do_cmd(OP_F, 1, 32'h0000FFFF, 32'h00005555, {1'b0, 32'h0000FFFF}, '0, 0, 0);
    do_cmd(OP_RD, 1, 32'h0, 32'h0, {1'b0, 32'hAAAA5555}, '0, 0, 0);
    do_cmd(OP_ST, 1, 32'h0, 32'h0, {1'b0, 32'h0000FFFF}, '0, 0, 0);
    do_cmd(OP_F, 1, 32'h0000000F, 32'h0000000A, {1'b0, 32'h0000FFFF}, '0, 0, 0);
    do_cmd(OP_RD, 1, 32'h0, 32'h0, {1'b0, 32'hAAAA555A}, '0, 0, 0);
    do_cmd(OP_R, 1, 32'hFFFF0000, 32'h0, {1'b0, 32'h0000FFFF}, '0, 0, 0);
    do_cmd(OP_R, 1, 32'h0000FFFF, 32'h0, {1'b0, 32'h0}, '0, 0, 0);
    check("r1_out", ov(1), 32'hAAAAAAAA);
    do_cmd(OP_F, 3, 32'h0, 32'hFFFFFFFF, {1'b0, 32'h0}, '0, 0, 0);
    check("mask0_out", ov(3), 32'hAAAAAAAA);
    check("mask0_forced_any", forced_any, 0);
    pulse(2, 32'hAAAAAAAA);
    do_cmd(OP_F, 2, 32'hFFFFFFFF, 32'h55555555, {1'b0, 32'hFFFFFFFF}, '0, 0, 0);
    pulse(2, 32'h12345678);
    check("v2_forced", ov(2), 32'h55555555);
    do_cmd(OP_R, 2, 32'hFFFFFFFF, 32'h0, {1'b0, 32'h0}, '0, 0, 0);
    check("v2_release_snap", snap[95:64], 32'h55555555);
    check("v2_release_hold", ov(2), 32'h55555555);
    pulse(2, 32'hAAAAAAAA);
    check("v2_drv_en", ov(2), 32'hAAAAAAAA);
    drv_val[95:64] = 32'hFFFFFFFF;
    do_cmd(OP_F, 2, 32'hFF000000, 32'h0, {1'b0, 32'hFF000000}, 4'b0100, 0, 0);
    check("conflict_snap", snap[95:64], 32'h00FFFFFF);
    do_cmd(OP_R, 2, 32'hFF000000, 32'h0, {1'b0, 32'h0}, '0, 0, 0);
    check("conflict_release", ov(2), 32'h00FFFFFF);
    do_cmd(OP_F, 0, 32'hFFFFFFFF, 32'hDEADBEEF, {1'b0, 32'hFFFFFFFF}, '0, 0, 0);
    do_cmd(OP_F, 7, 32'hFFFFFFFF, 32'h0, {1'b1, 32'h0}, '0, 5, 0);
    check("err_forced_any", forced_any, 4'b0001);
    check("err_out0", ov(0), 32'hDEADBEEF);
    do_cmd(OP_ST, 0, 32'h0, 32'h0, {1'b0, 32'hFFFFFFFF}, '0, 0, 1);
    @(negedge clk);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_rsp_data", bus.rsp_data, 0);
    check("abort_cmd_ready", bus.cmd_ready, 0);
    check("abort_forced_any", forced_any, 0);
    check("abort_out0", ov(0), 32'h12345678);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
